// File: rtl/axis_serializer.sv
// axis_serializer: width-reducing AXI-stream stage.
// Accepts one wide word of RATIO*WIDTH bits and emits RATIO narrow beats of
// WIDTH bits, least significant slice first. A one-word skid buffer behind the
// shift register keeps the output running back-to-back across word
// boundaries. Every output, iready included, comes straight from a flop.
module axis_serializer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [1:0]               size,
    input  logic [WIDTH*RATIO-1:0]   idata,
    input  logic                     ilast,
    input  logic                     ivalid,
    output logic                     iready,
    output logic [WIDTH-1:0]         odata,
    output logic                     olast,
    output logic                     ovalid,
    input  logic                     oready
);

    localparam int WW = WIDTH * RATIO;
    localparam int BW = $clog2(RATIO + 1);
    localparam logic [BW-1:0] BEATS_FULL = BW'(RATIO);
    localparam logic [BW-1:0] BEATS_ONE  = BW'(1);
    localparam logic [BW-1:0] BEATS_ZERO = '0;

    // Word being emitted and the skid buffer behind it
    logic [WW-1:0] shreg_q, shreg_d;
    logic [WW-1:0] buf_q,   buf_d;
    logic [BW-1:0] beats_q, beats_d;
    logic          slast_q, slast_d;
    logic          bfull_q, bfull_d;
    logic          blast_q, blast_d;

    // Output flops, loaded from the next-state values so they always
    // agree with the state they describe
    logic          ovalid_q, ovalid_d;
    logic          olast_q,  olast_d;
    logic          iready_q, iready_d;
    logic [1:0]    size_q,   size_d;

    logic          ifire;
    logic          ofire;
    logic          slot_free;

    assign ifire     = ivalid && iready_q;
    assign ofire     = ovalid_q && oready;
    // The shift register can take a new word this edge when it is empty
    // or its final beat is leaving right now.
    assign slot_free = (beats_q == BEATS_ZERO) || (ofire && (beats_q == BEATS_ONE));

    // Next-state logic for shift register, beat counter and skid buffer
    always_comb begin
        shreg_d = shreg_q;
        beats_d = beats_q;
        slast_d = slast_q;
        buf_d   = buf_q;
        bfull_d = bfull_q;
        blast_d = blast_q;

        if (ofire && (beats_q > BEATS_ONE)) begin
            shreg_d = {{WIDTH{1'b0}}, shreg_q[WW-1:WIDTH]};
            beats_d = beats_q - BEATS_ONE;
        end

        if (slot_free) begin
            if (bfull_q) begin
                // Buffered word has priority; iready is low so nothing
                // new can arrive this edge.
                shreg_d = buf_q;
                slast_d = blast_q;
                beats_d = BEATS_FULL;
                bfull_d = 1'b0;
            end else if (ifire) begin
                // Bypass the buffer so an idle stage adds no bubble
                shreg_d = idata;
                slast_d = ilast;
                beats_d = BEATS_FULL;
            end else begin
                beats_d = BEATS_ZERO;
            end
        end

        // Shift register busy: park the incoming word in the buffer.
        // ifire implies the buffer was empty.
        if (ifire && !(slot_free && !bfull_q)) begin
            buf_d   = idata;
            blast_d = ilast;
            bfull_d = 1'b1;
        end
    end

    // Output values for the next cycle, derived from next state
    always_comb begin
        ovalid_d = (beats_d != BEATS_ZERO);
        olast_d  = slast_d && (beats_d == BEATS_ONE);
        iready_d = !bfull_d;
        size_d   = {1'b0, (beats_d != BEATS_ZERO)} + {1'b0, bfull_d};
    end

    // Data registers carry no reset; their contents are ignored while empty
    always_ff @(posedge clock) begin
        shreg_q <= shreg_d;
        buf_q   <= buf_d;
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            beats_q  <= BEATS_ZERO;
            slast_q  <= 1'b0;
            bfull_q  <= 1'b0;
            blast_q  <= 1'b0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
            iready_q <= 1'b1;
            size_q   <= 2'd0;
        end else begin
            beats_q  <= beats_d;
            slast_q  <= slast_d;
            bfull_q  <= bfull_d;
            blast_q  <= blast_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
            iready_q <= iready_d;
            size_q   <= size_d;
        end
    end

    assign odata  = shreg_q[WIDTH-1:0];
    assign olast  = olast_q;
    assign ovalid = ovalid_q;
    assign iready = iready_q;
    assign size   = size_q;

endmodule

// File: tb/tb_axis_serializer.sv
// Directed and randomised checks for axis_serializer (WIDTH=8, RATIO=4).
module tb_axis_serializer;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  size;
    logic [31:0] idata;
    logic        ilast;
    logic        ivalid;
    logic        iready;
    logic [7:0]  odata;
    logic        olast;
    logic        ovalid;
    logic        oready;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    axis_serializer #(.WIDTH(8), .RATIO(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .size   (size),
        .idata  (idata),
        .ilast  (ilast),
        .ivalid (ivalid),
        .iready (iready),
        .odata  (odata),
        .olast  (olast),
        .ovalid (ovalid),
        .oready (oready)
    );

    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Check the presented beat, then let it transfer (oready assumed high)
    task automatic check_beat(input string tag, input logic [7:0] d, input logic l);
        check({tag, " ovalid"}, {31'd0, ovalid}, 32'd1);
        check({tag, " odata"},  {24'd0, odata},  {24'd0, d});
        check({tag, " olast"},  {31'd0, olast},  {31'd0, l});
        step();
    endtask

    logic [8:0]  sb[$];
    logic [8:0]  exp_beat;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;
    int          words_sent;
    int          ilast_cnt;
    int          olast_cnt;
    bit          done;

    initial begin
        reset  = 1'b1;
        idata  = '0;
        ilast  = 1'b0;
        ivalid = 1'b0;
        oready = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("reset ovalid", {31'd0, ovalid}, 32'd0);
        check("reset olast",  {31'd0, olast},  32'd0);
        check("reset iready", {31'd0, iready}, 32'd1);
        check("reset size",   {30'd0, size},   32'd0);

        // Single word
        idata = 32'h44332211; ilast = 1'b1; ivalid = 1'b1; oready = 1'b1;
        step();
        ivalid = 1'b0;
        check("single size", {30'd0, size}, 32'd1);
        check_beat("single b0", 8'h11, 1'b0);
        check_beat("single b1", 8'h22, 1'b0);
        check_beat("single b2", 8'h33, 1'b0);
        check_beat("single b3", 8'h44, 1'b1);
        check("single done ovalid", {31'd0, ovalid}, 32'd0);
        check("single done size",   {30'd0, size},   32'd0);
        $display("single word: done");

        // Back-to-back: second word is buffered while the first shifts out
        idata = 32'h44332211; ilast = 1'b0; ivalid = 1'b1; oready = 1'b1;
        step();
        idata = 32'h88776655; ilast = 1'b1;
        check("b2b iready w0", {31'd0, iready}, 32'd1);
        check_beat("b2b b0", 8'h11, 1'b0);
        ivalid = 1'b0;
        check("b2b size both", {30'd0, size},   32'd2);
        check("b2b iready full", {31'd0, iready}, 32'd0);
        check_beat("b2b b1", 8'h22, 1'b0);
        check_beat("b2b b2", 8'h33, 1'b0);
        check_beat("b2b b3", 8'h44, 1'b0);
        check("b2b iready freed", {31'd0, iready}, 32'd1);
        check("b2b size one",     {30'd0, size},   32'd1);
        check_beat("b2b b4", 8'h55, 1'b0);
        check_beat("b2b b5", 8'h66, 1'b0);
        check_beat("b2b b6", 8'h77, 1'b0);
        check_beat("b2b b7", 8'h88, 1'b1);
        check("b2b done ovalid", {31'd0, ovalid}, 32'd0);
        $display("back-to-back: done");

        // Backpressure
        oready = 1'b0;
        idata = 32'h44332211; ilast = 1'b0; ivalid = 1'b1;
        step();
        idata = 32'h88776655; ilast = 1'b1;
        check("bp odata w0", {24'd0, odata}, 32'h11);
        step();
        idata = 32'hCCCCCCCC; ilast = 1'b0;
        check("bp size 2",   {30'd0, size},   32'd2);
        check("bp iready 0", {31'd0, iready}, 32'd0);
        repeat (3) step();
        check("bp odata stuck", {24'd0, odata},  32'h11);
        check("bp ovalid held", {31'd0, ovalid}, 32'd1);
        check("bp iready held", {31'd0, iready}, 32'd0);
        ivalid = 1'b0; oready = 1'b1;
        check_beat("bp b0", 8'h11, 1'b0);
        check_beat("bp b1", 8'h22, 1'b0);
        check_beat("bp b2", 8'h33, 1'b0);
        check_beat("bp b3", 8'h44, 1'b0);
        check_beat("bp b4", 8'h55, 1'b0);
        check_beat("bp b5", 8'h66, 1'b0);
        check_beat("bp b6", 8'h77, 1'b0);
        check_beat("bp b7", 8'h88, 1'b1);
        check("bp done size", {30'd0, size}, 32'd0);
        $display("backpressure: done");

        // Random ivalid/oready over 1000 words with a beat scoreboard
        words_sent = 0; ilast_cnt = 0; olast_cnt = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
            if (prev_stall) begin
                check("rnd hold ovalid", {31'd0, ovalid}, 32'd1);
                check("rnd hold data", {23'd0, olast, odata}, {23'd0, prev_last, prev_data});
            end
            if (!iready) check("rnd notready implies ovalid", {31'd0, ovalid}, 32'd1);

            ivalid = (words_sent < 1000) && ($urandom_range(0, 1) == 1);
            idata  = $urandom;
            ilast  = ($urandom_range(0, 3) == 0);
            if (ivalid && iready) begin
                for (int j = 0; j < 4; j++)
                    sb.push_back({(ilast && j == 3), idata[j*8 +: 8]});
                words_sent++;
                if (ilast) ilast_cnt++;
            end

            oready = ($urandom_range(0, 1) == 1);
            if (ovalid && oready) begin
                if (sb.size() == 0) begin
                    check("rnd unexpected beat", {23'd0, olast, odata}, 32'hFFFFFFFF);
                end else begin
                    exp_beat = sb.pop_front();
                    check("rnd beat", {23'd0, olast, odata}, {23'd0, exp_beat});
                end
                if (olast) olast_cnt++;
            end

            prev_stall = ovalid && !oready;
            prev_data  = odata;
            prev_last  = olast;
            step();
            done = (words_sent == 1000) && (sb.size() == 0) && !ovalid;
        end
        ivalid = 1'b0;
        check("rnd completed", {31'd0, done}, 32'd1);
        check("rnd olast count", olast_cnt, ilast_cnt);
        $display("random: %0d words, %0d packets", words_sent, ilast_cnt);

        // Reset mid-word with a word waiting in the buffer
        oready = 1'b1;
        idata = 32'h44332211; ilast = 1'b0; ivalid = 1'b1;
        step();
        idata = 32'h88776655; ilast = 1'b1;
        check("rst b0", {24'd0, odata}, 32'h11);
        step();
        ivalid = 1'b0;
        check("rst b1", {24'd0, odata}, 32'h22);
        check("rst size before", {30'd0, size}, 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst ovalid", {31'd0, ovalid}, 32'd0);
        check("rst iready", {31'd0, iready}, 32'd1);
        check("rst size",   {30'd0, size},   32'd0);
        idata = 32'hDDCCBBAA; ilast = 1'b1; ivalid = 1'b1;
        step();
        ivalid = 1'b0;
        check_beat("post rst b0", 8'hAA, 1'b0);
        check_beat("post rst b1", 8'hBB, 1'b0);
        check_beat("post rst b2", 8'hCC, 1'b0);
        check_beat("post rst b3", 8'hDD, 1'b1);
        check("post rst empty", {31'd0, ovalid}, 32'd0);
        $display("reset mid-word: done");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
